// File: rtl/rv32v_mask_sequencer_if.sv
// Handshake/bus bundle between vector uop issue and rv32v_mask_sequencer.
//   master : issue side (drives start/abort/operands/stall, observes uop stream)
//   slave  : the sequencer (samples operands, drives the uop stream)
interface rv32v_mask_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 128,
  parameter int MAX_NF    = 8,
  parameter int UOP_W     = $clog2(VLEN*MAX_NF),
  parameter int VL_W      = $clog2(VLEN+1)
);
  logic                 start;
  logic                 abort;
  logic [VLEN-1:0]      v0;
  logic                 mask_enable;
  logic [VL_W-1:0]      vl;
  logic [VL_W-1:0]      vstart;
  logic                 is_seg_op;
  logic [2:0]           nf;
  logic                 stall;

  logic                 busy;
  logic                 uop_valid;
  logic [UOP_W-1:0]     uop_num;
  logic [VL_W-1:0]      elem_base;
  logic [2:0]           field_num;
  logic [NUM_LANES-1:0] lane_mask;
  logic [NUM_LANES-1:0] mask_bits;
  logic                 last_uop;
  logic                 done;

  modport master (
    output start, abort, v0, mask_enable, vl, vstart, is_seg_op, nf, stall,
    input  busy, uop_valid, uop_num, elem_base, field_num, lane_mask,
           mask_bits, last_uop, done
  );

  modport slave (
    input  start, abort, v0, mask_enable, vl, vstart, is_seg_op, nf, stall,
    output busy, uop_valid, uop_num, elem_base, field_num, lane_mask,
           mask_bits, last_uop, done
  );
endinterface

// File: rtl/rv32v_mask_sequencer.sv
// Vector mask sequencer: snapshots v0/vl/vstart/mode on start and walks every
// micro-op of the instruction, producing per-uop lane mask, raw v0 bits,
// element base and last-uop flag, paced by a stall/accept handshake.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : rv32v_mask_sequencer_if.slave (operands in, uop stream out)
//
// state | meaning
// IDLE  | waiting for start; operands sampled on start
// RUN   | presenting uops; advance on uop_valid & ~stall
// FIN   | one-cycle done pulse, then back to IDLE
module rv32v_mask_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 128,
  parameter int MAX_NF    = 8,
  parameter int UOP_W     = $clog2(VLEN*MAX_NF),
  parameter int VL_W      = $clog2(VLEN+1)
) (
  input logic                    CLK,
  input logic                    nRST,
  rv32v_mask_sequencer_if.slave  bus
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [VL_W-1:0] VLEN_V  = VL_W'(VLEN);
  localparam logic [VL_W-1:0] NL_V    = VL_W'(NUM_LANES);
  localparam logic [VL_W:0]   NL_W1   = (VL_W+1)'(NUM_LANES);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q, state_d;
  logic [VLEN-1:0]      v0_q;
  logic [VL_W-1:0]      vl_q, vstart_q;
  logic                 me_q, seg_q;
  logic [2:0]           nf_q;

  logic [UOP_W-1:0]     uop_num_q, uop_num_d;
  logic [VL_W-1:0]      base_q, base_d;
  logic [2:0]           field_q, field_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [NUM_LANES-1:0] lane_q, bits_q;
  logic                 last_q;
  logic                 load_outs, clear_outs;

  logic [VL_W-1:0]      cap_vl;
  logic [VLEN-1:0]      src_v0;
  logic [VL_W-1:0]      src_vl, src_vs;
  logic                 src_me, src_seg;
  logic [2:0]           src_nf;

  logic [VLEN-1:0]      v0_sh;
  logic [LANE_W-1:0]    lane_i;
  logic [VL_W:0]        elem;
  logic                 act;
  logic [NUM_LANES-1:0] eval_lane, eval_bits;
  logic                 eval_last;

  logic accept;

  assign cap_vl = (bus.vl > VLEN_V) ? VLEN_V : bus.vl;
  assign accept = valid_q & ~bus.stall;

  // The first uop's masks are evaluated from the live inputs in the same
  // cycle they are captured, so the uop appears one cycle after start.
  assign src_v0  = (state_q == IDLE) ? bus.v0          : v0_q;
  assign src_vl  = (state_q == IDLE) ? cap_vl          : vl_q;
  assign src_vs  = (state_q == IDLE) ? bus.vstart      : vstart_q;
  assign src_me  = (state_q == IDLE) ? bus.mask_enable : me_q;
  assign src_seg = (state_q == IDLE) ? bus.is_seg_op   : seg_q;
  assign src_nf  = (state_q == IDLE) ? bus.nf          : nf_q;

  always_comb begin
    state_d    = state_q;
    uop_num_d  = uop_num_q;
    base_d     = base_q;
    field_d    = field_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    load_outs  = 1'b0;
    clear_outs = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.vstart >= cap_vl) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d   = RUN;
            valid_d   = 1'b1;
            uop_num_d = '0;
            field_d   = '0;
            base_d    = bus.is_seg_op ? bus.vstart : (bus.vstart & ~(NL_V - VL_W'(1)));
            load_outs = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort || (accept && last_q)) begin
          state_d    = FIN;
          valid_d    = 1'b0;
          done_d     = 1'b1;
          clear_outs = 1'b1;
        end else if (accept) begin
          uop_num_d = uop_num_q + UOP_W'(1);
          load_outs = 1'b1;
          if (seg_q) begin
            if (field_q == nf_q) begin
              field_d = '0;
              base_d  = base_q + VL_W'(1);
            end else begin
              field_d = field_q + 3'd1;
            end
          end else begin
            base_d = base_q + NL_V;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Masks and last flag for the uop described by base_d/field_d.
  always_comb begin
    eval_lane = '0;
    eval_bits = '0;
    eval_last = 1'b0;
    elem      = '0;
    act       = 1'b0;
    v0_sh     = src_v0 >> base_d;
    lane_i    = LANE_W'(base_d % NL_V);
    if (src_seg) begin
      eval_bits[lane_i] = v0_sh[0];
      eval_lane[lane_i] = src_me ? v0_sh[0] : 1'b1;
      eval_last         = (base_d == src_vl - VL_W'(1)) && (field_d == src_nf);
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        elem = {1'b0, base_d} + (VL_W+1)'(i);
        act  = (elem >= {1'b0, src_vs}) && (elem < {1'b0, src_vl});
        eval_bits[i] = act & v0_sh[i];
        eval_lane[i] = act & (src_me ? v0_sh[i] : 1'b1);
      end
      eval_last = ({1'b0, base_d} + NL_W1) >= {1'b0, src_vl};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      v0_q      <= '0;
      vl_q      <= '0;
      vstart_q  <= '0;
      me_q      <= 1'b0;
      seg_q     <= 1'b0;
      nf_q      <= '0;
      uop_num_q <= '0;
      base_q    <= '0;
      field_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      lane_q    <= '0;
      bits_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      uop_num_q <= uop_num_d;
      base_q    <= base_d;
      field_q   <= field_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      if (state_q == IDLE && bus.start) begin
        v0_q     <= bus.v0;
        vl_q     <= cap_vl;
        vstart_q <= bus.vstart;
        me_q     <= bus.mask_enable;
        seg_q    <= bus.is_seg_op;
        nf_q     <= bus.nf;
      end
      if (load_outs) begin
        lane_q <= eval_lane;
        bits_q <= eval_bits;
        last_q <= eval_last;
      end else if (clear_outs) begin
        lane_q <= '0;
        bits_q <= '0;
        last_q <= 1'b0;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.uop_valid = valid_q;
  assign bus.uop_num   = uop_num_q;
  assign bus.elem_base = base_q;
  assign bus.field_num = field_q;
  assign bus.lane_mask = lane_q;
  assign bus.mask_bits = bits_q;
  assign bus.last_uop  = last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_rv32v_mask_sequencer.sv
module tb_rv32v_mask_sequencer;
  localparam int NL = 4;
  localparam int VL = 128;

  typedef logic [3:0] nib8_t [8];
  typedef logic [7:0] byte8_t [8];
  typedef logic [2:0] tri8_t [8];

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_errors;

  logic [3:0] r_lane [8];
  logic [3:0] r_bits [8];
  logic [7:0] r_base [8];
  logic [2:0] r_field[8];
  logic [9:0] r_num  [8];
  logic       r_last [8];

  rv32v_mask_sequencer_if #(.NUM_LANES(NL), .VLEN(VL)) bus ();

  rv32v_mask_sequencer #(.NUM_LANES(NL), .VLEN(VL)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [VL-1:0] v0v, input logic [7:0] vlv, input logic [7:0] vsv,
                          input logic me, input logic seg, input logic [2:0] nfv);
    bus.v0          = v0v;
    bus.vl          = vlv;
    bus.vstart      = vsv;
    bus.mask_enable = me;
    bus.is_seg_op   = seg;
    bus.nf          = nfv;
    bus.start       = 1'b1;
    tick();
    bus.start       = 1'b0;
    // operands changing mid-op must not matter
    bus.v0          = '0;
    bus.vl          = 8'd0;
    bus.vstart      = 8'd99;
    bus.mask_enable = ~me;
    bus.is_seg_op   = ~seg;
    bus.nf          = 3'd7;
  endtask

  task automatic collect(output int n, output int dcyc);
    n    = 0;
    dcyc = -1;
    for (int c = 0; c < 40; c++) begin
      if (bus.uop_valid && n < 8) begin
        r_lane[n]  = bus.lane_mask;
        r_bits[n]  = bus.mask_bits;
        r_base[n]  = bus.elem_base;
        r_field[n] = bus.field_num;
        r_num[n]   = bus.uop_num;
        r_last[n]  = bus.last_uop;
        n++;
      end
      if (bus.done) begin
        dcyc = c;
        break;
      end
      tick();
    end
  endtask

  task automatic verify(input string name, input int n_exp, input nib8_t el, input nib8_t eb,
                        input byte8_t ebase, input tri8_t ef, input logic [7:0] elast);
    int n;
    int dcyc;
    collect(n, dcyc);
    check({name, ".count"}, n, n_exp);
    check({name, ".done_cyc"}, dcyc, n_exp);
    for (int i = 0; i < n_exp && i < n; i++) begin
      check($sformatf("%s.lane%0d", name, i), r_lane[i], el[i]);
      check($sformatf("%s.bits%0d", name, i), r_bits[i], eb[i]);
      check($sformatf("%s.base%0d", name, i), r_base[i], ebase[i]);
      check($sformatf("%s.field%0d", name, i), r_field[i], ef[i]);
      check($sformatf("%s.num%0d", name, i), r_num[i], i);
      check($sformatf("%s.last%0d", name, i), r_last[i], elast[i]);
    end
    tick();
    check({name, ".done_clr"}, bus.done, 1'b0);
    check({name, ".idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    nrst            = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.stall       = 1'b0;
    bus.v0          = '0;
    bus.vl          = '0;
    bus.vstart      = '0;
    bus.mask_enable = 1'b0;
    bus.is_seg_op   = 1'b0;
    bus.nf          = '0;
    #2;
    check("rst.busy", bus.busy, 1'b0);
    check("rst.valid", bus.uop_valid, 1'b0);
    check("rst.done", bus.done, 1'b0);
    check("rst.last", bus.last_uop, 1'b0);
    check("rst.outs", {bus.uop_num, bus.elem_base, bus.field_num, bus.lane_mask, bus.mask_bits}, '0);
    #10 nrst = 1'b1;
    tick();

    start_op({VL{1'b1}}, 8'd10, 8'd0, 1'b0, 1'b0, 3'd0);
    verify("full", 3, '{4'hF, 4'hF, 4'h3, 0, 0, 0, 0, 0}, '{4'hF, 4'hF, 4'h3, 0, 0, 0, 0, 0},
           '{8'd0, 8'd4, 8'd8, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'b0000_0100);

    start_op(128'hA6, 8'd8, 8'd0, 1'b1, 1'b0, 3'd0);
    verify("vm", 2, '{4'h6, 4'hA, 0, 0, 0, 0, 0, 0}, '{4'h6, 4'hA, 0, 0, 0, 0, 0, 0},
           '{8'd0, 8'd4, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'b0000_0010);

    start_op(128'h2, 8'd2, 8'd0, 1'b1, 1'b1, 3'd2);
    verify("seg", 6, '{4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 0, 0}, '{4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 0, 0},
           '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 0, 0}, '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 0, 0}, 8'b0010_0000);

    start_op({VL{1'b1}}, 8'd9, 8'd6, 1'b0, 1'b0, 3'd0);
    verify("vstart", 2, '{4'hC, 4'h1, 0, 0, 0, 0, 0, 0}, '{4'hC, 4'h1, 0, 0, 0, 0, 0, 0},
           '{8'd4, 8'd8, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'b0000_0010);

    start_op({4'h5, 4'h3, 120'h0}, 8'd200, 8'd120, 1'b0, 1'b0, 3'd0);
    verify("clamp", 2, '{4'hF, 4'hF, 0, 0, 0, 0, 0, 0}, '{4'h3, 4'h5, 0, 0, 0, 0, 0, 0},
           '{8'd120, 8'd124, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'b0000_0010);

    start_op({VL{1'b1}}, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0);
    verify("empty", 0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
           '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'b0);

    // stall on uop 1 for three cycles, then abort while still stalled
    start_op({VL{1'b1}}, 8'd10, 8'd0, 1'b0, 1'b0, 3'd0);
    tick();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall.valid%0d", k), bus.uop_valid, 1'b1);
      check($sformatf("stall.num%0d", k), bus.uop_num, 10'd1);
      check($sformatf("stall.base%0d", k), bus.elem_base, 8'd4);
      check($sformatf("stall.lane%0d", k), bus.lane_mask, 4'hF);
      check($sformatf("stall.last%0d", k), bus.last_uop, 1'b0);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    check("abort.valid", bus.uop_valid, 1'b0);
    check("abort.done", bus.done, 1'b1);
    check("abort.busy", bus.busy, 1'b1);
    tick();
    check("abort.done_clr", bus.done, 1'b0);
    check("abort.idle", bus.busy, 1'b0);

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_idle.done", bus.done, 1'b0);
    check("abort_idle.busy", bus.busy, 1'b0);

    // reset asserted mid-RUN
    start_op({VL{1'b1}}, 8'd10, 8'd0, 1'b0, 1'b0, 3'd0);
    tick();
    check("midrst.pre_valid", bus.uop_valid, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check("midrst.valid", bus.uop_valid, 1'b0);
    check("midrst.busy", bus.busy, 1'b0);
    check("midrst.outs", {bus.uop_num, bus.elem_base, bus.field_num, bus.lane_mask, bus.mask_bits, bus.last_uop}, '0);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("midrst.nodone%0d", k), bus.done, 1'b0);
    end
    check("midrst.idle", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
